// File: rtl/register_file_param.sv
// Parametrised register file: asynchronous reads, synchronous write, optional hardwired-zero r0, clear sweep FSM.
// Zero-latency reads; the writer must hold off while busy. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module register_file_param #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clk_enable,
  input  logic [READ_PORTS*ADDR_W-1:0] read_addr,
  output logic [READ_PORTS*DATA_W-1:0] read_data,
  input  logic                         write_enable,
  input  logic [ADDR_W-1:0]            write_address,
  input  logic [DATA_W-1:0]            write_data,
  input  logic                         clear_req,
  output logic                         busy
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   counter;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_zero;
  logic                wr_ok;

  // A clear request in the same cycle wins over a pending write.
  assign wr_zero = (ZERO_REG != 0) && (write_address == '0);
  assign wr_ok   = clk_enable && write_enable && (state == IDLE) && !clear_req && !wr_zero;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      counter <= '0;
      busy    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clk_enable) begin
      case (state)
        IDLE: begin
          if (clear_req) begin
            state   <= CLEAR;
            counter <= '0;
            busy    <= 1'b1;
          end else if (wr_ok) begin
            mem[write_address] <= write_data;
          end
        end
        CLEAR: begin
          mem[counter] <= '0;
          counter      <= counter + 1'b1;
          if (&counter) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] stored;

    assign ra     = read_addr[k*ADDR_W +: ADDR_W];
    assign stored = ((ZERO_REG != 0) && (ra == '0)) ? '0 : mem[ra];
`ifdef REGFILE_BYPASS_EN
    assign read_data[k*DATA_W +: DATA_W] = (wr_ok && (write_address == ra)) ? write_data : stored;
`else
    assign read_data[k*DATA_W +: DATA_W] = stored;
`endif
  end

endmodule

// File: tb/tb_register_file_param.sv
// Scoreboard bench for register_file_param: stimulus queues expected read/busy values, a negedge monitor compares them.
module tb_register_file_param;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_enable;
  logic [9:0]  read_addr;
  logic [63:0] read_data;
  logic        write_enable;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic        clear_req;
  logic        busy;

  typedef struct {
    int          sel;   // 0: read port 0, 1: read port 1, 2: busy
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  register_file_param dut (
    .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable),
    .read_addr(read_addr), .read_data(read_data),
    .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
    .clear_req(clear_req), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       act = read_data[31:0];
        1:       act = read_data[63:32];
        default: act = {31'b0, busy};
      endcase
      n_vec++;
      if (act !== e.val) begin
        n_err++;
        $display("FAIL %s: got %h want %h", e.name, act, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.sel = sel; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
    read_addr = {a1, a0};
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    write_enable = 1'b1; write_address = a; write_data = d;
    step();
    write_enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; clk_enable = 1'b1; read_addr = '0;
    write_enable = 1'b0; write_address = '0; write_data = '0; clear_req = 1'b0;
    step(); step();
    reset_n = 1'b1;

    // 1: reset state
    expect_v(2, 32'd0, "reset_busy");
    for (int a = 0; a < 32; a++) begin
      set_ra(5'(a), 5'(31 - a));
      expect_v(0, 32'd0, "reset_rd0");
      expect_v(1, 32'd0, "reset_rd1");
      step();
    end

    // 2: write/read and hardwired zero
    write(5'd5, 32'hDEADBEEF);
    set_ra(5'd5, 5'd5);
    expect_v(0, 32'hDEADBEEF, "r5_rd0");
    expect_v(1, 32'hDEADBEEF, "r5_rd1");
    step();
    write(5'd0, 32'hDEADBEEF);
    set_ra(5'd0, 5'd0);
    expect_v(0, 32'd0, "r0_rd0");
    expect_v(1, 32'd0, "r0_rd1");
    step();

    // 3: clk_enable stall
    clk_enable = 1'b0;
    write(5'd7, 32'h1234);
    clk_enable = 1'b1;
    set_ra(5'd7, 5'd7);
    expect_v(0, 32'd0, "r7_stalled");
    step();
    write(5'd7, 32'h1234);
    expect_v(1, 32'h1234, "r7_written");
    step();

    // 4: fill, then sweep
    for (int i = 1; i < 32; i++) write(5'(i), 32'(i * 32'h11));
    set_ra(5'd1, 5'd31);
    expect_v(0, 32'h11, "fill_r1");
    expect_v(1, 32'h20F, "fill_r31");
    clear_req = 1'b1;
    write_enable = 1'b1; write_address = 5'd2; write_data = 32'hFFFF;
    step();
    clear_req = 1'b0;
    for (int c = 0; c < 32; c++) begin
      write_enable = (c == 12); write_address = 5'd25; write_data = 32'hBAD;
      expect_v(2, 32'd1, "sweep_busy");
      if (c == 1) begin
        set_ra(5'd2, 5'd31);
        expect_v(0, 32'h22, "sweep_r2_write_dropped");
        expect_v(1, 32'h20F, "sweep_r31_early");
      end else if (c == 10) begin
        set_ra(5'd3, 5'd20);
        expect_v(0, 32'd0, "sweep_r3_cleared");
        expect_v(1, 32'h154, "sweep_r20_old");
      end else if (c == 13) begin
        set_ra(5'd25, 5'd24);
        expect_v(0, 32'h1A9, "sweep_r25_write_dropped");
        expect_v(1, 32'h198, "sweep_r24_old");
      end else if (c == 31) begin
        set_ra(5'd30, 5'd31);
        expect_v(0, 32'd0, "sweep_r30_cleared");
        expect_v(1, 32'h20F, "sweep_r31_last");
      end
      step();
    end
    write_enable = 1'b0;
    expect_v(2, 32'd0, "sweep_done_busy");
    for (int a = 0; a < 32; a++) begin
      set_ra(5'(a), 5'(31 - a));
      expect_v(0, 32'd0, "post_sweep_rd0");
      expect_v(1, 32'd0, "post_sweep_rd1");
      step();
    end

    // 5: reset in the middle of a sweep
    write(5'd30, 32'h77);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      expect_v(2, 32'd1, "sweep2_busy");
      step();
    end
    reset_n = 1'b0;
    #1;
    set_ra(5'd30, 5'd7);
    expect_v(2, 32'd0, "midreset_busy");
    expect_v(0, 32'd0, "midreset_r30");
    expect_v(1, 32'd0, "midreset_r7");
    step();
    reset_n = 1'b1;
    step();
    write(5'd9, 32'hA5A5A5A5);
    set_ra(5'd9, 5'd30);
    expect_v(0, 32'hA5A5A5A5, "post_reset_r9");
    expect_v(1, 32'd0, "post_reset_r30");
    expect_v(2, 32'd0, "post_reset_busy");
    step();

    // 6: same-cycle write/read forwarding
    set_ra(5'd12, 5'd12);
    write_enable = 1'b1; write_address = 5'd12; write_data = 32'hCAFEF00D;
`ifdef REGFILE_BYPASS_EN
    expect_v(0, 32'hCAFEF00D, "bypass_same_cycle");
`else
    expect_v(0, 32'd0, "nobypass_same_cycle");
`endif
    step();
    write_enable = 1'b0;
    expect_v(0, 32'hCAFEF00D, "r12_next_cycle");
    expect_v(1, 32'hCAFEF00D, "r12_rd1");
    step();
    set_ra(5'd0, 5'd0);
    write_enable = 1'b1; write_address = 5'd0; write_data = 32'h5555;
    expect_v(0, 32'd0, "r0_no_forward");
    step();
    write_enable = 1'b0;
    expect_v(1, 32'd0, "r0_after_write");
    step();

    step();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
